// File: rtl/l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : l2_cacheline_adaptor
// Brief    : Bridges one 256-bit L2 line request to a 64-bit multi-beat memory burst.
//            Optional macro ADAPTOR_PERF_CNT_EN enables completed read/write counters.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cacheline_adaptor #(
    parameter int S_OFFSET    = 5,
    parameter int S_LINE      = 8 * 2**S_OFFSET,
    parameter int BURST_WIDTH = 64,
    parameter int NUM_BEATS   = S_LINE / BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            line_addr,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [S_LINE-1:0]      line_wdata,
    output logic [S_LINE-1:0]      line_rdata,
    output logic                   line_resp,
    output logic [31:0]            mem_address,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);

    localparam int c_idx_w = $clog2(NUM_BEATS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_idx_w-1:0]  r_beat_idx;
    logic [S_LINE-1:0]   r_wbuf;
    logic                w_last;
    logic [c_idx_w-1:0]  w_next_idx;
    logic                w_unused_addr_bits;

    assign w_last             = (r_beat_idx == c_last_idx);
    assign w_next_idx         = r_beat_idx + c_idx_w'(1);
    assign w_unused_addr_bits = ^line_addr[S_OFFSET-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat_idx  <= '0;
            r_wbuf      <= '0;
            line_rdata  <= '0;
            line_resp   <= 1'b0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Read has priority if the L2 ever raises both requests.
                    if (line_read) begin
                        mem_address <= {line_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        mem_read    <= 1'b1;
                        r_state     <= ST_READ;
                    end else if (line_write) begin
                        mem_address <= {line_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        r_wbuf      <= line_wdata;
                        mem_wdata   <= line_wdata[BURST_WIDTH-1:0];
                        mem_write   <= 1'b1;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (mem_resp) begin
                        line_rdata[r_beat_idx*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata;
                        if (w_last) begin
                            mem_read  <= 1'b0;
                            line_resp <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_beat_idx <= w_next_idx;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_resp) begin
                        if (w_last) begin
                            mem_write <= 1'b0;
                            line_resp <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            mem_wdata  <= r_wbuf[w_next_idx*BURST_WIDTH +: BURST_WIDTH];
                            r_beat_idx <= w_next_idx;
                        end
                    end
                end
                ST_DONE: begin
                    line_resp  <= 1'b0;
                    r_beat_idx <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADAPTOR_PERF_CNT_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (mem_resp && w_last) begin
            if (r_state == ST_READ)
                r_rd_count <= r_rd_count + 32'd1;
            if (r_state == ST_WRITE)
                r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 32'h0;
    assign wr_count = 32'h0;
`endif

endmodule
`default_nettype wire
